ddr3_iod_dly_sequencer: RTL and testbench
=========================================

// Module: ddr3_iod_dly_sequencer
// PURPOSE
//  Sequences the dynamic delay-line controls (LOAD/MOVE/DIRECTION) of NUM_LANES DDR3 PHY IOD lanes.
//  Accepts one tap-target request at a time and drives that lane's delay line to the target in unit steps.
//  Tracks the current tap of every lane and reports completion and errors.
//  Sits between training/calibration logic and the per-lane IOD wrappers (CKE, CA, DQ) in the DDRPHY block.
// PARAMETERS
//  NUM_LANES  4    number of IOD lanes controlled
//  TAP_W      8    width of tap counters and targets
//  MAX_TAP    127  highest legal tap; targets above it are rejected
//  MOVE_GAP   2    idle cycles after each MOVE pulse (>=1)
// PORTS
//  FAB_CLK                  in   1                  fabric clock, all logic rising-edge
//  SYNC_RST                 in   1                  synchronous active-high reset
//  REQ_VALID                in   1                  request valid
//  REQ_READY                out  1                  request accepted when VALID&READY
//  REQ_LANE                 in   $clog2(NUM_LANES)  target lane (NUM_LANES=1 -> width 1, ignored)
//  REQ_TAP                  in   TAP_W              target tap
//  REQ_LOAD                 in   1                  1 = reload lane to tap 0 before stepping
//  DONE                     out  1                  1-cycle pulse, request finished
//  ERR                      out  1                  valid with DONE: request rejected or aborted
//  DELAY_LINE_LOAD          out  NUM_LANES          per-lane load strobe
//  DELAY_LINE_MOVE          out  NUM_LANES          per-lane move strobe
//  DELAY_LINE_DIRECTION     out  NUM_LANES          per-lane direction, 1 = increment
//  DELAY_LINE_OUT_OF_RANGE  in   NUM_LANES          per-lane out-of-range flag from IOD
// BEHAVIOUR
//  - Reset: state IDLE; REQ_READY=0 during the reset cycle, 1 from the first cycle after it;
//    DONE=ERR=0; all LOAD/MOVE/DIRECTION=0; all tap counters=0.
//  - FSM: IDLE -> [LOAD -> SETTLE] -> SETUP -> (STEP -> GAP x MOVE_GAP)* -> FIN -> IDLE.
//  - IDLE: REQ_READY=1. On accept, latch lane/tap/load. If REQ_TAP>MAX_TAP: go to FIN with ERR=1,
//    no strobes. Else go to LOAD if REQ_LOAD, otherwise to SETUP.
//  - LOAD: DELAY_LINE_LOAD[lane]=1 for exactly 1 cycle; tap[lane] := 0. SETTLE: 1 idle cycle.
//  - SETUP: DIRECTION[lane] := (target > tap[lane]). Held stable until FIN.
//    Equal target and tap -> FIN.
//  - STEP: MOVE[lane]=1 for 1 cycle; tap[lane] +/- 1. Then MOVE_GAP GAP cycles with MOVE=0.
//    After the gap: reached target -> FIN, else -> STEP.
//  - FIN: DONE=1 for 1 cycle (ERR as set); DIRECTION cleared to 0. REQ_READY=1 the following cycle.
//  - Latency, accept at cycle T (legal target): DONE at T + 2 + (REQ_LOAD ? 2 : 0) + |delta|*(1+MOVE_GAP).
//  - Out of range: OUT_OF_RANGE[lane] seen high in any GAP cycle aborts to FIN with ERR=1.
//    tap[lane] keeps the value after the last move. Other lanes' flags are ignored.
//  - Only the selected lane's strobes are ever asserted. At most one MOVE/LOAD bit is high per cycle.
//  - Tap arithmetic is unsigned TAP_W bits. A counter never decrements below 0 or exceeds MAX_TAP,
//    because targets are range-checked first.
//  - SYNC_RST mid-operation: the next cycle gives full reset values. A strobe in flight is
//    dropped and no DONE is issued.
//  - REQ_* is sampled only on accept; changes while busy are ignored.
// CONFIGURATION
//  DDR3_DLY_READBACK_EN defined: adds ports RD_LANE (in, $clog2(NUM_LANES)) and RD_TAP (out, TAP_W).
//    RD_TAP = tap[RD_LANE], registered with 1-cycle latency, 0 in reset.
//  Not defined: the ports are absent. The tap counters remain internal.
// TESTING
//  1 reset, lane 1, tap 3, load 0, MOVE_GAP 2, accept T0 -> DIR[1]=1 from T1; MOVE[1] at T2,T5,T8;
//    DONE at T11, ERR=0.
//  2 after 1, lane 1, tap 1, load 0 -> DIR[1]=0; 2 MOVE pulses; DONE at T0+8; readback tap 1.
//  3 lane 2, tap 2, load 1 -> LOAD[2] at T1; MOVE[2] at T4,T7; DONE at T10; no other lane strobes.
//  4 tap 200 (>127) -> no strobes; DONE+ERR at T0+1; lane tap unchanged.
//  5 lane 0 stepping to 10, OUT_OF_RANGE[0]=1 after 4th move -> DONE+ERR;
//    tap[0]=4; REQ_READY the next cycle.
//  6 SYNC_RST during a GAP -> next cycle all outputs 0, taps 0, no DONE;
//    new request behaves as in test 1.

Source files
------------

// File: rtl/ddr3_iod_dly_sequencer_if.sv
// Request/completion interface between training logic and the IOD delay sequencer.
// The master issues one tap-target request at a time; the slave reports DONE/ERR.
interface ddr3_iod_dly_sequencer_if #(
    parameter int NUM_LANES = 4,
    parameter int TAP_W     = 8
);
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic              req_valid;
    logic              req_ready;
    logic [LANE_W-1:0] req_lane;
    logic [TAP_W-1:0]  req_tap;
    logic              req_load;
    logic              done;
    logic              err;

    modport master (
        output req_valid, req_lane, req_tap, req_load,
        input  req_ready, done, err
    );

    modport slave (
        input  req_valid, req_lane, req_tap, req_load,
        output req_ready, done, err
    );
endinterface

// File: rtl/ddr3_iod_dly_sequencer.sv
// Drives the LOAD/MOVE/DIRECTION controls of NUM_LANES DDR3 IOD delay lines,
// stepping one lane at a time to a requested tap and tracking every lane's tap.
// Optional build macro DDR3_DLY_READBACK_EN adds rd_lane/rd_tap tap readback.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | ready for a request
// S_LOAD   | load strobe on the selected lane, lane tap forced to 0
// S_SETTLE | one quiet cycle after a load
// S_SETUP  | direction valid; decide whether any steps are needed
// S_STEP   | move strobe on the selected lane, tap updated
// S_GAP    | quiet cycles after a move; out-of-range flag checked here
// S_FIN    | done pulse (err if rejected/aborted), direction released
module ddr3_iod_dly_sequencer #(
    parameter int NUM_LANES = 4,
    parameter int TAP_W     = 8,
    parameter int MAX_TAP   = 127,
    parameter int MOVE_GAP  = 2,
    localparam int LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                 fab_clk,
    input  logic                 sync_rst,
    ddr3_iod_dly_sequencer_if.slave req,
    output logic [NUM_LANES-1:0] delay_line_load,
    output logic [NUM_LANES-1:0] delay_line_move,
    output logic [NUM_LANES-1:0] delay_line_direction,
    input  logic [NUM_LANES-1:0] delay_line_out_of_range
`ifdef DDR3_DLY_READBACK_EN
    ,
    input  logic [LANE_W-1:0]    rd_lane,
    output logic [TAP_W-1:0]     rd_tap
`endif
);
    localparam int GAP_W = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;
    localparam logic [TAP_W-1:0] MAX_TAP_V = TAP_W'(MAX_TAP);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_SETUP, S_STEP, S_GAP, S_FIN
    } state_t;

    state_t            state;
    logic [LANE_W-1:0] lane_q;
    logic [TAP_W-1:0]  target_q;
    logic [GAP_W-1:0]  gap_cnt;
    logic [TAP_W-1:0]  taps [NUM_LANES];

    logic [NUM_LANES-1:0] sel;
    logic [NUM_LANES-1:0] req_sel;
    logic [TAP_W-1:0]     cur_tap;
    logic [TAP_W-1:0]     req_cur_tap;
    logic [TAP_W-1:0]     next_tap;

    // Lane decode and the tap value one step towards the target.
    always_comb begin
        sel              = '0;
        sel[lane_q]      = 1'b1;
        req_sel          = '0;
        req_sel[req.req_lane] = 1'b1;
        cur_tap          = taps[lane_q];
        req_cur_tap      = taps[req.req_lane];
        next_tap         = delay_line_direction[lane_q] ? cur_tap + TAP_W'(1)
                                                        : cur_tap - TAP_W'(1);
    end

    // Sequencer FSM with registered strobes, handshake and tap counters.
    always_ff @(posedge fab_clk) begin
        if (sync_rst) begin
            state                <= S_IDLE;
            lane_q               <= '0;
            target_q             <= '0;
            gap_cnt              <= '0;
            req.req_ready        <= 1'b0;
            req.done             <= 1'b0;
            req.err              <= 1'b0;
            delay_line_load      <= '0;
            delay_line_move      <= '0;
            delay_line_direction <= '0;
            for (int i = 0; i < NUM_LANES; i++) taps[i] <= '0;
        end else begin
            req.req_ready   <= 1'b0;
            req.done        <= 1'b0;
            req.err         <= 1'b0;
            delay_line_load <= '0;
            delay_line_move <= '0;
            case (state)
                S_IDLE: begin
                    req.req_ready <= 1'b1;
                    if (req.req_valid && req.req_ready) begin
                        req.req_ready <= 1'b0;
                        lane_q        <= req.req_lane;
                        target_q      <= req.req_tap;
                        if (req.req_tap > MAX_TAP_V) begin
                            state    <= S_FIN;
                            req.done <= 1'b1;
                            req.err  <= 1'b1;
                        end else if (req.req_load) begin
                            state                 <= S_LOAD;
                            delay_line_load       <= req_sel;
                            taps[req.req_lane]    <= '0;
                        end else begin
                            state                <= S_SETUP;
                            delay_line_direction <= (req.req_tap > req_cur_tap) ? req_sel : '0;
                        end
                    end
                end
                S_LOAD: state <= S_SETTLE;
                S_SETTLE: begin
                    state                <= S_SETUP;
                    delay_line_direction <= (target_q > cur_tap) ? sel : '0;
                end
                S_SETUP: begin
                    if (target_q == cur_tap) begin
                        state                <= S_FIN;
                        req.done             <= 1'b1;
                        delay_line_direction <= '0;
                    end else begin
                        state           <= S_STEP;
                        delay_line_move <= sel;
                        taps[lane_q]    <= next_tap;
                    end
                end
                S_STEP: begin
                    state   <= S_GAP;
                    gap_cnt <= GAP_W'(MOVE_GAP - 1);
                end
                S_GAP: begin
                    if (delay_line_out_of_range[lane_q]) begin
                        state                <= S_FIN;
                        req.done             <= 1'b1;
                        req.err              <= 1'b1;
                        delay_line_direction <= '0;
                    end else if (gap_cnt == '0) begin
                        if (cur_tap == target_q) begin
                            state                <= S_FIN;
                            req.done             <= 1'b1;
                            delay_line_direction <= '0;
                        end else begin
                            state           <= S_STEP;
                            delay_line_move <= sel;
                            taps[lane_q]    <= next_tap;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                S_FIN: begin
                    state         <= S_IDLE;
                    req.req_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DDR3_DLY_READBACK_EN
    // Registered readback of any lane's current tap.
    always_ff @(posedge fab_clk) begin
        if (sync_rst) rd_tap <= '0;
        else          rd_tap <= taps[rd_lane];
    end
`else
    // Tap counters stay internal in this build.
`endif
endmodule

// File: tb/tb_ddr3_iod_dly_sequencer.sv
// Self-checking bench for ddr3_iod_dly_sequencer: a request-level model expands
// each request into the expected per-cycle output trace; a negedge process compares.
module tb_ddr3_iod_dly_sequencer;
    localparam int N = 4;
    localparam int G = 2;

    typedef struct {
        logic       dn;
        logic       er;
        logic [3:0] ld;
        logic [3:0] mv;
        logic [3:0] dr;
        logic       gap;
        logic       hit;
    } ent_t;

    logic       clk;
    logic       sync_rst;
    logic [3:0] dl_load, dl_move, dl_dir, dl_oor;
    logic [1:0] rd_lane, rd_prev;
    logic [7:0] rd_tap;

    ddr3_iod_dly_sequencer_if #(.NUM_LANES(N), .TAP_W(8)) bus ();

    ddr3_iod_dly_sequencer #(.NUM_LANES(N), .TAP_W(8), .MAX_TAP(127), .MOVE_GAP(G)) dut (
        .fab_clk                 (clk),
        .sync_rst                (sync_rst),
        .req                     (bus),
        .delay_line_load         (dl_load),
        .delay_line_move         (dl_move),
        .delay_line_direction    (dl_dir),
        .delay_line_out_of_range (dl_oor)
`ifdef DDR3_DLY_READBACK_EN
        ,
        .rd_lane                 (rd_lane),
        .rd_tap                  (rd_tap)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_en = 0;
    bit rd_en = 0;
    logic       e_rdy, e_dn, e_er;
    logic [3:0] e_ld, e_mv, e_dr;
    logic [7:0] e_rd;
    int mtap [N];
    int last_done_cyc;
    logic last_err;
    int mv_log[$];
    int ld_log[$];
    ent_t tl[$];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Every-cycle comparison of DUT outputs against the model trace.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("req_ready", {31'd0, bus.req_ready}, {31'd0, e_rdy});
            cmp("done",      {31'd0, bus.done},      {31'd0, e_dn});
            cmp("err",       {31'd0, bus.err},       {31'd0, e_er});
            cmp("load",      {28'd0, dl_load},       {28'd0, e_ld});
            cmp("move",      {28'd0, dl_move},       {28'd0, e_mv});
            cmp("direction", {28'd0, dl_dir},        {28'd0, e_dr});
`ifdef DDR3_DLY_READBACK_EN
            if (rd_en) cmp("rd_tap", {24'd0, rd_tap}, {24'd0, e_rd});
`endif
            if (bus.done === 1'b1) begin
                last_done_cyc = cyc;
                last_err      = bus.err;
            end
            if (dl_move != 4'd0) mv_log.push_back(cyc);
            if (dl_load != 4'd0) ld_log.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        rd_prev = rd_lane;
    endtask

    task automatic rand_inputs();
        bus.req_lane = 2'($urandom_range(0, 3));
        bus.req_tap  = 8'($urandom);
        bus.req_load = 1'($urandom);
        dl_oor       = 4'($urandom);
        rd_lane      = 2'($urandom_range(0, 3));
    endtask

    task automatic set_zero_exp(input logic rdy);
        e_rdy = rdy; e_dn = 0; e_er = 0; e_ld = 0; e_mv = 0; e_dr = 0;
    endtask

    task automatic idle_cycle();
        tick();
        set_zero_exp(1'b1);
        rd_en = 1;
        e_rd  = 8'(mtap[rd_prev]);
        bus.req_valid = 1'b0;
        rand_inputs();
    endtask

    // Expand one request into its expected output trace from the tap rules.
    task automatic build(input int lane, input int tap, input bit load,
                         input int ak, input int aj, output int ft);
        ent_t e, z;
        logic [3:0] b;
        int cur, n;
        bit up, ab;
        z = '{dn: 0, er: 0, ld: 0, mv: 0, dr: 0, gap: 0, hit: 0};
        b = 4'(1 << lane);
        tl.delete();
        if (tap > 127) begin
            e = z; e.dn = 1; e.er = 1; tl.push_back(e);
            ft = mtap[lane];
        end else begin
            cur = load ? 0 : mtap[lane];
            if (load) begin
                e = z; e.ld = b; tl.push_back(e);
                tl.push_back(z);
            end
            up = tap > cur;
            n  = up ? tap - cur : cur - tap;
            e = z; e.dr = up ? b : 4'd0; tl.push_back(e);
            ab = 0;
            for (int k = 1; k <= n && !ab; k++) begin
                e = z; e.mv = b; e.dr = up ? b : 4'd0; tl.push_back(e);
                cur = up ? cur + 1 : cur - 1;
                for (int j = 1; j <= G && !ab; j++) begin
                    e = z; e.dr = up ? b : 4'd0; e.gap = 1;
                    e.hit = (k == ak && j == aj);
                    tl.push_back(e);
                    if (e.hit) ab = 1;
                end
            end
            e = z; e.dn = 1; e.er = ab; tl.push_back(e);
            ft = cur;
        end
    endtask

    // Issue a request in the current ready cycle and play out its trace.
    task automatic issue(input int lane, input int tap, input bit load,
                         input int ak, input int aj, input int rst_at, output int acc);
        int ft;
        acc = cyc;
        last_done_cyc = -1;
        mv_log.delete();
        ld_log.delete();
        bus.req_valid = 1'b1;
        bus.req_lane  = 2'(lane);
        bus.req_tap   = 8'(tap);
        bus.req_load  = load;
        build(lane, tap, load, ak, aj, ft);
        for (int i = 0; i < tl.size(); i++) begin
            tick();
            e_rdy = 0; e_dn = tl[i].dn; e_er = tl[i].er;
            e_ld = tl[i].ld; e_mv = tl[i].mv; e_dr = tl[i].dr;
            rd_en = 0;
            rand_inputs();
            bus.req_valid = 1'($urandom_range(0, 1));
            if (tl[i].gap) dl_oor[lane] = tl[i].hit;
            if (i + 1 == rst_at) begin
                sync_rst = 1'b1;
                tick();
                set_zero_exp(1'b0);
                for (int l = 0; l < N; l++) mtap[l] = 0;
                rd_en = 1; e_rd = 8'd0;
                sync_rst = 1'b0;
                bus.req_valid = 1'b0;
                return;
            end
        end
        mtap[lane] = ft;
    endtask

    initial begin
        int acc, ak, tap, nreq;
        sync_rst = 1'b1;
        bus.req_valid = 1'b0;
        rd_lane = 0; rd_prev = 0;
        rand_inputs();
        for (int l = 0; l < N; l++) mtap[l] = 0;
        last_done_cyc = -1;
        last_err = 0;
        tick();
        set_zero_exp(1'b0);
        rd_en = 1; e_rd = 8'd0;
        chk_en = 1;
        tick();
        sync_rst = 1'b0;
        idle_cycle();

        // 1: lane 1 up to tap 3
        issue(1, 3, 0, 0, 0, 0, acc);
        idle_cycle();
        cmp("t1_done_at", last_done_cyc - acc, 11);
        cmp("t1_err", {31'd0, last_err}, 0);
        cmp("t1_moves", mv_log.size(), 3);
        if (mv_log.size() == 3) begin
            cmp("t1_mv0", mv_log[0] - acc, 2);
            cmp("t1_mv2", mv_log[2] - acc, 8);
        end

        // 2: lane 1 back down to tap 1
        issue(1, 1, 0, 0, 0, 0, acc);
        idle_cycle();
        cmp("t2_done_at", last_done_cyc - acc, 8);
        cmp("t2_moves", mv_log.size(), 2);
        cmp("t2_model_tap", mtap[1], 1);

        // 3: lane 2 with reload
        issue(2, 2, 1, 0, 0, 0, acc);
        idle_cycle();
        cmp("t3_done_at", last_done_cyc - acc, 10);
        cmp("t3_loads", ld_log.size(), 1);
        if (ld_log.size() == 1) cmp("t3_load_at", ld_log[0] - acc, 1);
        if (mv_log.size() == 2) cmp("t3_mv1", mv_log[1] - acc, 7);
        else cmp("t3_moves", mv_log.size(), 2);

        // 4: illegal target
        issue(3, 200, 0, 0, 0, 0, acc);
        idle_cycle();
        cmp("t4_done_at", last_done_cyc - acc, 1);
        cmp("t4_err", {31'd0, last_err}, 1);
        cmp("t4_moves", mv_log.size(), 0);

        // 5: out-of-range abort after the 4th move
        issue(0, 10, 0, 4, 2, 0, acc);
        idle_cycle();
        cmp("t5_done_at", last_done_cyc - acc, 14);
        cmp("t5_err", {31'd0, last_err}, 1);
        cmp("t5_model_tap", mtap[0], 4);

        // 6: reset in the gap after the 2nd move, then repeat test 1
        issue(0, 20, 0, 0, 0, 6, acc);
        idle_cycle();
        cmp("t6_no_done", last_done_cyc, -1);
        cmp("t6_model_tap", mtap[0], 0);
        issue(1, 3, 0, 0, 0, 0, acc);
        idle_cycle();
        cmp("t6_done_at", last_done_cyc - acc, 11);

        // Random requests
        nreq = 60;
        for (int r = 0; r < nreq; r++) begin
            tap = ($urandom_range(0, 7) == 0) ? $urandom_range(128, 255) : $urandom_range(0, 127);
            ak  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 40) : 0;
            issue($urandom_range(0, 3), tap, 1'($urandom), ak, $urandom_range(1, G), 0, acc);
            idle_cycle();
            for (int k = $urandom_range(0, 2); k > 0; k--) idle_cycle();
        end

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
